trace_pingpong_buffer: RTL
==========================

// Module: trace_pingpong_buffer
// PURPOSE
//  Double-buffered (ping-pong) column trace store between the ray tracer and the row renderer.
//  Tracer streams one frame of per-column traces (height, side, tex) into the back bank.
//  Renderer randomly reads the front bank every line; banks swap only on a frame-boundary request
//  once the back bank holds a complete frame.
//  Separate read and write ports replace bidirectional data pins.
// PARAMETERS
//  COLUMNS   640                 traces per frame, i.e. depth of each bank
//  HEIGHT_W  8                   height field width
//  TEX_W     6                   texture field width
//  COL_W     $clog2(COLUMNS)     column index width; derived, not overridden
// PORTS
//  clk         in   1        single clock; all logic on posedge
//  reset_n     in   1        asynchronous, active-low reset
//  wr_valid    in   1        tracer offers a trace this cycle
//  wr_ready    out  1        buffer accepts; transfer = wr_valid & wr_ready
//  wr_height   in   HEIGHT_W trace height
//  wr_side     in   1        wall side flag
//  wr_tex      in   TEX_W    texture id
//  wr_restart  in   1        abort partial frame; write column returns to 0
//  wr_column   out  COL_W    column the next accepted write lands in
//  back_full   out  1        back bank holds COLUMNS traces awaiting swap
//  swap_req    in   1        frame-boundary strobe (e.g. vsync start)
//  swap_done   out  1        1-cycle pulse: swap performed
//  front_sel   out  1        bank index currently read by renderer
//  front_valid out  1        front bank holds a complete frame (0 until first swap)
//  rd_en       in   1        renderer read strobe
//  rd_column   in   COL_W    column to read
//  rd_valid    out  1        rd_* data valid (rd_en delayed 1 cycle)
//  rd_height   out  HEIGHT_W read data
//  rd_side     out  1        read data
//  rd_tex      out  TEX_W    read data
// BEHAVIOUR
//  Reset: front_sel=0, wr_column=0, back_full=0, front_valid=0, swap_done=0, rd_valid=0,
//   rd_* data=0. Bank RAM contents are not reset.
//  Write: wr_ready = !back_full & !wr_restart.
//   Each transfer writes {height,side,tex} to bank !front_sel at wr_column, then wr_column++.
//   The transfer at column COLUMNS-1 sets back_full and wraps wr_column to 0.
//   While back_full=1, further wr_valid is stalled (held off), never dropped.
//  wr_restart: wr_column<=0, back_full<=0, no write that cycle. Takes priority over swap_req.
//  Swap: on swap_req with registered back_full=1:
//   front_sel toggles, back_full<=0, front_valid<=1, swap_done pulses 1 cycle later.
//  swap_req with back_full=0: ignored. Renderer keeps the old frame (repeat), and partial writes
//   continue. A last-column write and swap_req in the same cycle do not swap; the next
//   swap_req does.
//  Read: 1-cycle latency. Data is registered from the bank selected by front_sel at the rd_en edge.
//   A read issued in the swap cycle returns old-front data.
//  rd_column >= COLUMNS, or front_valid=0: rd_valid still pulses; data=0.
//  Without rd_en, rd_* data holds its last value. Read and write never touch the same bank,
//   so no collision rule is needed.
//  Reset mid-frame: all state returns to reset values; the in-flight partial frame is discarded.
// STRUCTURE
//  Shared include trace_defs.vh: TRACE_W = HEIGHT_W+1+TEX_W; field offsets for packing
//   {height,side,tex}; default COLUMNS/HEIGHT_W/TEX_W.
//  Sub-module trace_bank: simple dual-port RAM (1 write, 1 registered read), depth COLUMNS,
//   width TRACE_W, instantiated twice.
//   Top holds the write counter, back_full/front_sel control and output muxing.
// TESTING
//  1 Reset, then read col 5 -> rd_valid next cycle, data 0, front_valid=0, front_sel=0.
//  2 Stream 640 writes (height=col[7:0], side=col[0], tex=col[5:0]), then swap_req ->
//    swap_done pulse, front_sel=1. Read col 300 -> height 0x2C, side 0, tex 0x2C.
//  3 Hold wr_valid after 640th write -> wr_ready=0, wr_column=0, back_full=1.
//    No write lands until swap.
//  4 swap_req after only 100 writes -> no swap, front data unchanged, wr_column=100.
//    Finish 540 writes, swap_req -> swap.
//  5 Last write and swap_req same cycle -> no swap_done.
//    Next swap_req -> swap. Read in swap cycle returns old frame.
//  6 wr_restart at col 200 -> wr_column=0, back_full=0.
//    reset_n low mid-frame -> all outputs at reset values asynchronously.
//  Also: rd_column=700 -> data 0. Random write/read/swap traffic checked against a 2-bank model.

Source files
------------

// File: rtl/trace_pingpong_buffer_pkg.sv
// rtl/trace_pingpong_buffer_pkg.sv - shared defaults and trace field layout helpers
package trace_pingpong_buffer_pkg;

  localparam int DEF_COLUMNS  = 640;
  localparam int DEF_HEIGHT_W = 8;
  localparam int DEF_TEX_W    = 6;

  // A packed trace is {height, side, tex} with tex in the low bits.
  function automatic int trace_width(input int height_w, input int tex_w);
    return height_w + 1 + tex_w;
  endfunction

  function automatic int side_lsb(input int tex_w);
    return tex_w;
  endfunction

  function automatic int height_lsb(input int tex_w);
    return tex_w + 1;
  endfunction

endpackage

// File: rtl/trace_pingpong_buffer_bank.sv
// rtl/trace_pingpong_buffer_bank.sv - one trace bank: simple dual-port RAM with registered read
module trace_bank
  import trace_pingpong_buffer_pkg::*;
#(
  parameter int DEPTH  = DEF_COLUMNS,
  parameter int WIDTH  = 15,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; the caller only ever presents in-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; output holds between reads.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_pingpong_buffer.sv
// rtl/trace_pingpong_buffer.sv - ping-pong column trace store between tracer and renderer
module trace_pingpong_buffer
  import trace_pingpong_buffer_pkg::*;
#(
  parameter int  COLUMNS  = DEF_COLUMNS,
  parameter int  HEIGHT_W = DEF_HEIGHT_W,
  parameter int  TEX_W    = DEF_TEX_W,
  localparam int COL_W    = $clog2(COLUMNS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [HEIGHT_W-1:0] wr_height,
  input  logic                wr_side,
  input  logic [TEX_W-1:0]    wr_tex,
  input  logic                wr_restart,
  output logic [COL_W-1:0]    wr_column,
  output logic                back_full,
  input  logic                swap_req,
  output logic                swap_done,
  output logic                front_sel,
  output logic                front_valid,
  input  logic                rd_en,
  input  logic [COL_W-1:0]    rd_column,
  output logic                rd_valid,
  output logic [HEIGHT_W-1:0] rd_height,
  output logic                rd_side,
  output logic [TEX_W-1:0]    rd_tex
);

  localparam int               TRACE_W    = trace_width(HEIGHT_W, TEX_W);
  localparam int               SIDE_LSB   = side_lsb(TEX_W);
  localparam int               HEIGHT_LSB = height_lsb(TEX_W);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLUMNS - 1);

  logic               wr_fire;
  logic               swap_fire;
  logic               rd_in_range;
  logic               rd_hit;
  logic               rd_zero;
  logic               rd_sel;
  logic [TRACE_W-1:0] wr_word;
  logic [TRACE_W-1:0] rd_word0;
  logic [TRACE_W-1:0] rd_word1;
  logic [TRACE_W-1:0] rd_word;

  // A restart cycle never writes; a full back bank holds the tracer off.
  assign wr_ready  = !back_full && !wr_restart;
  assign wr_fire   = wr_valid && wr_ready;
  // Only a frame already complete before this edge may be swapped in.
  assign swap_fire = swap_req && back_full && !wr_restart;
  assign wr_word   = {wr_height, wr_side, wr_tex};

  assign rd_in_range = int'(rd_column) < COLUMNS;
  assign rd_hit      = rd_en && front_valid && rd_in_range;

  // Bank 0 is the back bank while bank 1 is in front, and vice versa.
  trace_bank #(.DEPTH(COLUMNS), .WIDTH(TRACE_W), .ADDR_W(COL_W)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_fire && front_sel),
    .wr_addr (wr_column),
    .wr_data (wr_word),
    .rd_en   (rd_hit && !front_sel),
    .rd_addr (rd_column),
    .rd_data (rd_word0)
  );

  trace_bank #(.DEPTH(COLUMNS), .WIDTH(TRACE_W), .ADDR_W(COL_W)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_fire && !front_sel),
    .wr_addr (wr_column),
    .wr_data (wr_word),
    .rd_en   (rd_hit && front_sel),
    .rd_addr (rd_column),
    .rd_data (rd_word1)
  );

  // Write column, back-bank fill state and bank swap control.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_column   <= '0;
      back_full   <= 1'b0;
      front_sel   <= 1'b0;
      front_valid <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      swap_done <= swap_fire;
      if (wr_restart) begin
        wr_column <= '0;
        back_full <= 1'b0;
      end else if (swap_fire) begin
        front_sel   <= !front_sel;
        back_full   <= 1'b0;
        front_valid <= 1'b1;
      end else if (wr_fire) begin
        if (wr_column == LAST_COL) begin
          wr_column <= '0;
          back_full <= 1'b1;
        end else begin
          wr_column <= wr_column + COL_W'(1);
        end
      end
    end
  end

  // Remember which bank answered the last read, or that it must read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_zero  <= 1'b1;
      rd_sel   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_zero <= !rd_hit;
        rd_sel  <= front_sel;
      end
    end
  end

  assign rd_word   = rd_zero ? '0 : (rd_sel ? rd_word1 : rd_word0);
  assign rd_height = rd_word[HEIGHT_LSB +: HEIGHT_W];
  assign rd_side   = rd_word[SIDE_LSB];
  assign rd_tex    = rd_word[TEX_W-1:0];

endmodule
